// File: rtl/hazard_fwd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_pkg
// Shared definitions for the 5-stage MIPS hazard / forwarding controller:
//   - forwarding select codes driven to the D, E and M operand muxes
//   - the "source not used" Tuse code
//   - stage record types tracked for the instructions in E, M and W
//   - Tnew ageing helper
// -----------------------------------------------------------------------------
package hazard_fwd_ctrl_pkg;

   localparam int REC_AW = 5;   // register address width held in the records
   localparam int REC_TW = 2;   // Tnew / Tuse width held in the records

   // Forwarding select codes (D muxes use all four, E muxes 0..2, M mux 0..1)
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_W  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_E  = 2'd3;

   // Tuse value meaning "this source register is not read"
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Destination half of a record: who is written and how many cycles until
   // the result exists.
   typedef struct packed {
      logic [REC_AW-1:0] a3;
      logic [REC_TW-1:0] tnew;
   } dst_t;

   // Full stage record {A3, Tnew, rs, rt}, as held for the instruction in E.
   typedef struct packed {
      dst_t              dst;
      logic [REC_AW-1:0] rs;
      logic [REC_AW-1:0] rt;
   } stage_rec_t;

   // M-stage record: the only M-stage consumer of a source register is the
   // store-data mux, which reads rt, so rs is not carried past E.
   typedef struct packed {
      dst_t              dst;
      logic [REC_AW-1:0] rt;
   } m_rec_t;

   // Tnew one stage later: max(tnew - 1, 0)
   function automatic logic [REC_TW-1:0] tnew_dec(input logic [REC_TW-1:0] t);
      logic [REC_TW-1:0] r;
      if (t == {REC_TW{1'b0}}) begin
         r = {REC_TW{1'b0}};
      end else begin
         r = t - {{(REC_TW-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_pick.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl_fwd_sel_pick
// Chooses the forwarding source for one source register. The nearest stage
// holding the register as its destination wins (E over M over W); if that
// stage's result is not ready yet (Tnew > 0) the select stays at the
// register-file / own-value path and the stall logic covers the hazard.
//
// Ports:
//   src    in   REC_AW  source register being read
//   e_en   in   1       allow the E record to be considered
//   m_en   in   1       allow the M record to be considered
//   e_dst  in   dst_t   E record destination/Tnew
//   m_dst  in   dst_t   M record destination/Tnew
//   w_dst  in   dst_t   W record destination/Tnew
//   sel    out  2       FWD_RF / FWD_W / FWD_M / FWD_E
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl_fwd_sel_pick
   import hazard_fwd_ctrl_pkg::*;
(
   input  logic [REC_AW-1:0] src,
   input  logic              e_en,
   input  logic              m_en,
   input  dst_t              e_dst,
   input  dst_t              m_dst,
   input  dst_t              w_dst,
   output logic [1:0]        sel
);

   // Priority pick: $0 never forwards; a nearer match that is not ready
   // blocks older stages rather than falling through to them.
   always_comb begin
      sel = FWD_RF;
      if (src == {REC_AW{1'b0}}) begin
         sel = FWD_RF;
      end else if (e_en && (e_dst.a3 == src)) begin
         sel = (e_dst.tnew == {REC_TW{1'b0}}) ? FWD_E : FWD_RF;
      end else if (m_en && (m_dst.a3 == src)) begin
         sel = (m_dst.tnew == {REC_TW{1'b0}}) ? FWD_M : FWD_RF;
      end else if (w_dst.a3 == src) begin
         sel = (w_dst.tnew == {REC_TW{1'b0}}) ? FWD_W : FWD_RF;
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for a 5-stage MIPS pipeline (F/D/E/M/W).
// Tracks destination register and Tnew of the instructions in E, M and W,
// raises the D-stage stall when a source is needed before it can be produced,
// and generates the forwarding selects for the D, E and M operand muxes.
//
// Ports:
//   clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-high; clears all records
//   D_rs, D_rt    in   REG_AW  source registers of the instruction in D
//   D_Tuse_rs/rt  in   TW      cycles until D needs rs/rt (3 = unused)
//   D_A3          in   REG_AW  destination of D's instruction (0 = none)
//   D_Tnew        in   TW      Tnew on entering E
//   stall         out  1       freeze PC and F/D, bubble into D/E
//   D_fwd_rs_sel  out  2       0 = RF, 1 = W, 2 = M, 3 = E
//   D_fwd_rt_sel  out  2       same encoding
//   E_fwd_a_sel   out  2       0 = E_RD1, 1 = W, 2 = M
//   E_fwd_b_sel   out  2       0 = E_RD2, 1 = W, 2 = M
//   M_fwd_rt_sel  out  1       0 = M_RD2, 1 = W
//   stall_cnt     out  CNT_W   number of stalled cycles (wraps)
//
// Stall and selects are combinational from the records and D inputs; the
// records themselves advance on the next rising edge. REG_AW and TW must
// match REC_AW / REC_TW in the package.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int TW     = 2,
   parameter int CNT_W  = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] D_rs,
   input  logic [REG_AW-1:0] D_rt,
   input  logic [TW-1:0]     D_Tuse_rs,
   input  logic [TW-1:0]     D_Tuse_rt,
   input  logic [REG_AW-1:0] D_A3,
   input  logic [TW-1:0]     D_Tnew,
   output logic              stall,
   output logic [1:0]        D_fwd_rs_sel,
   output logic [1:0]        D_fwd_rt_sel,
   output logic [1:0]        E_fwd_a_sel,
   output logic [1:0]        E_fwd_b_sel,
   output logic              M_fwd_rt_sel,
   output logic [CNT_W-1:0]  stall_cnt
);

   stage_rec_t       e_q, e_d;
   m_rec_t           m_q, m_d;
   dst_t             w_q, w_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             stall_s;
   logic             rs_live_s, rt_live_s;
   logic [1:0]       m_rt_pick_s;

   // Stall: a live source collides with an E/M producer whose result arrives
   // after the source is needed. W always has Tnew = 0 and is never checked.
   always_comb begin
      rs_live_s = (|D_rs) && (D_Tuse_rs != TUSE_NONE);
      rt_live_s = (|D_rt) && (D_Tuse_rt != TUSE_NONE);
      stall_s   = (rs_live_s && (e_q.dst.a3 == D_rs) && (D_Tuse_rs < e_q.dst.tnew)) ||
                  (rs_live_s && (m_q.dst.a3 == D_rs) && (D_Tuse_rs < m_q.dst.tnew)) ||
                  (rt_live_s && (e_q.dst.a3 == D_rt) && (D_Tuse_rt < e_q.dst.tnew)) ||
                  (rt_live_s && (m_q.dst.a3 == D_rt) && (D_Tuse_rt < m_q.dst.tnew));
   end

   // Next record values: a stall injects a bubble into E while M and W keep
   // draining, so older producers continue to age towards Tnew = 0.
   always_comb begin
      if (stall_s) begin
         e_d.dst.a3   = {REC_AW{1'b0}};
         e_d.dst.tnew = {REC_TW{1'b0}};
         e_d.rs       = {REC_AW{1'b0}};
         e_d.rt       = {REC_AW{1'b0}};
         stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         e_d.dst.a3   = D_A3;
         e_d.dst.tnew = D_Tnew;
         e_d.rs       = D_rs;
         e_d.rt       = D_rt;
         stall_cnt_d  = stall_cnt_q;
      end
      m_d.dst.a3   = e_q.dst.a3;
      m_d.dst.tnew = tnew_dec(e_q.dst.tnew);
      m_d.rt       = e_q.rt;
      w_d.a3       = m_q.dst.a3;
      w_d.tnew     = tnew_dec(m_q.dst.tnew);
   end

   // Stage records and stall counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q         <= '{dst: '{a3: {REC_AW{1'b0}}, tnew: {REC_TW{1'b0}}},
                          rs: {REC_AW{1'b0}}, rt: {REC_AW{1'b0}}};
         m_q         <= '{dst: '{a3: {REC_AW{1'b0}}, tnew: {REC_TW{1'b0}}},
                          rt: {REC_AW{1'b0}}};
         w_q         <= '{a3: {REC_AW{1'b0}}, tnew: {REC_TW{1'b0}}};
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         e_q         <= e_d;
         m_q         <= m_d;
         w_q         <= w_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // D-stage selects may take E, M or W
   hazard_fwd_ctrl_fwd_sel_pick u_pick_d_rs (
      .src   (D_rs),
      .e_en  (1'b1),
      .m_en  (1'b1),
      .e_dst (e_q.dst),
      .m_dst (m_q.dst),
      .w_dst (w_q),
      .sel   (D_fwd_rs_sel)
   );

   hazard_fwd_ctrl_fwd_sel_pick u_pick_d_rt (
      .src   (D_rt),
      .e_en  (1'b1),
      .m_en  (1'b1),
      .e_dst (e_q.dst),
      .m_dst (m_q.dst),
      .w_dst (w_q),
      .sel   (D_fwd_rt_sel)
   );

   // E-stage selects look back at M and W only, for the E record's sources
   hazard_fwd_ctrl_fwd_sel_pick u_pick_e_a (
      .src   (e_q.rs),
      .e_en  (1'b0),
      .m_en  (1'b1),
      .e_dst (e_q.dst),
      .m_dst (m_q.dst),
      .w_dst (w_q),
      .sel   (E_fwd_a_sel)
   );

   hazard_fwd_ctrl_fwd_sel_pick u_pick_e_b (
      .src   (e_q.rt),
      .e_en  (1'b0),
      .m_en  (1'b1),
      .e_dst (e_q.dst),
      .m_dst (m_q.dst),
      .w_dst (w_q),
      .sel   (E_fwd_b_sel)
   );

   // M-stage store data can only come from W
   hazard_fwd_ctrl_fwd_sel_pick u_pick_m_rt (
      .src   (m_q.rt),
      .e_en  (1'b0),
      .m_en  (1'b0),
      .e_dst (e_q.dst),
      .m_dst (m_q.dst),
      .w_dst (w_q),
      .sel   (m_rt_pick_s)
   );

   assign M_fwd_rt_sel = (m_rt_pick_s == FWD_W);
   assign stall        = stall_s;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed scenarios followed by random instruction streams. The reference
// model keeps each in-flight instruction with the absolute cycle at which its
// result becomes available; Tnew at any moment is derived from that.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  D_rs, D_rt, D_A3;
   logic [1:0]  D_Tuse_rs, D_Tuse_rt, D_Tnew;
   logic        stall;
   logic [1:0]  D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_a_sel, E_fwd_b_sel;
   logic        M_fwd_rt_sel;
   logic [31:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: index 0 = E, 1 = M, 2 = W
   int          cyc = 0;
   int          st_a3    [3];
   int          st_ready [3];
   int          st_rs    [3];
   int          st_rt    [3];
   logic [31:0] m_cnt;

   logic        obs_stall;
   logic [1:0]  obs_drs, obs_drt;
   logic        exp_stall_last;
   int          ns;

   hazard_fwd_ctrl #(.REG_AW(5), .TW(2), .CNT_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .D_rs         (D_rs),
      .D_rt         (D_rt),
      .D_Tuse_rs    (D_Tuse_rs),
      .D_Tuse_rt    (D_Tuse_rt),
      .D_A3         (D_A3),
      .D_Tnew       (D_Tnew),
      .stall        (stall),
      .D_fwd_rs_sel (D_fwd_rs_sel),
      .D_fwd_rt_sel (D_fwd_rt_sel),
      .E_fwd_a_sel  (E_fwd_a_sel),
      .E_fwd_b_sel  (E_fwd_b_sel),
      .M_fwd_rt_sel (M_fwd_rt_sel),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int tnew_now(input int s);
      return (st_ready[s] > cyc) ? (st_ready[s] - cyc) : 0;
   endfunction

   function automatic logic m_hazard(input logic [4:0] src, input logic [1:0] tuse);
      for (int s = 0; s < 2; s++) begin
         if (src != 5'd0 && tuse != 2'd3 && st_a3[s] == int'(src) && int'(tuse) < tnew_now(s))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   // Nearest producer at or after stage 'first'; stage code E=3, M=2, W=1
   function automatic logic [1:0] m_fwd(input int src, input int first);
      for (int s = first; s < 3; s++) begin
         if (src != 0 && st_a3[s] == src)
            return (tnew_now(s) == 0) ? 2'(3 - s) : 2'd0;
      end
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         st_a3[s] = 0; st_ready[s] = 0; st_rs[s] = 0; st_rt[s] = 0;
      end
      m_cnt = 32'd0;
   endtask

   // One clock: drive D, check all outputs mid-cycle, advance model at the edge
   task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] a3, input logic [1:0] tn);
      logic       e_stall;
      logic [1:0] e_drs, e_drt, e_ea, e_eb;
      logic       e_m;
      D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt; D_A3 = a3; D_Tnew = tn;
      @(negedge clk);
      e_stall = m_hazard(rs, tu_rs) || m_hazard(rt, tu_rt);
      e_drs   = m_fwd(int'(rs), 0);
      e_drt   = m_fwd(int'(rt), 0);
      e_ea    = m_fwd(st_rs[0], 1);
      e_eb    = m_fwd(st_rt[0], 1);
      e_m     = (m_fwd(st_rt[1], 2) == 2'd1);
      obs_stall = stall; obs_drs = D_fwd_rs_sel; obs_drt = D_fwd_rt_sel;
      chk("stall",        {31'd0, stall},        {31'd0, e_stall});
      chk("D_fwd_rs_sel", {30'd0, D_fwd_rs_sel}, {30'd0, e_drs});
      chk("D_fwd_rt_sel", {30'd0, D_fwd_rt_sel}, {30'd0, e_drt});
      chk("E_fwd_a_sel",  {30'd0, E_fwd_a_sel},  {30'd0, e_ea});
      chk("E_fwd_b_sel",  {30'd0, E_fwd_b_sel},  {30'd0, e_eb});
      chk("M_fwd_rt_sel", {31'd0, M_fwd_rt_sel}, {31'd0, e_m});
      chk("stall_cnt",    stall_cnt,             m_cnt);
      exp_stall_last = e_stall;
      @(posedge clk);
      cyc++;
      for (int s = 2; s > 0; s--) begin
         st_a3[s] = st_a3[s-1]; st_ready[s] = st_ready[s-1];
         st_rs[s] = st_rs[s-1]; st_rt[s] = st_rt[s-1];
      end
      if (e_stall) begin
         st_a3[0] = 0; st_ready[0] = cyc; st_rs[0] = 0; st_rt[0] = 0;
         m_cnt = m_cnt + 32'd1;
      end else begin
         st_a3[0] = int'(a3); st_ready[0] = cyc + int'(tn);
         st_rs[0] = int'(rs); st_rt[0] = int'(rt);
      end
      #1;
   endtask

   // Present one instruction until it leaves D; nstall counts observed stalls
   task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                        input logic [4:0] a3, input logic [1:0] tn, output int nstall);
      int guard;
      guard  = 0;
      nstall = 0;
      step(rs, rt, tu_rs, tu_rt, a3, tn);
      nstall += (obs_stall === 1'b1) ? 1 : 0;
      while (exp_stall_last && guard < 4) begin
         guard++;
         step(rs, rt, tu_rs, tu_rt, a3, tn);
         nstall += (obs_stall === 1'b1) ? 1 : 0;
      end
   endtask

   task automatic nops(input int n);
      int d;
      for (int i = 0; i < n; i++) issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, d);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_sels"},  {23'd0, D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_a_sel, E_fwd_b_sel, M_fwd_rt_sel}, 32'd0);
      chk({tag, "_cnt"},   stall_cnt, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_A3 = 5'd0; D_Tnew = 2'd0;
      model_reset();
      #2;
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // ALU -> dependent ALU: no stall, M forward into E, then W forward into D
      issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, 2'd1, ns);
      issue(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, ns);
      chk("alu_alu_stalls", ns, 32'd0);
      chk("alu_alu_e_a_m", {30'd0, E_fwd_a_sel}, 32'd2);
      nops(1);
      issue(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, ns);
      chk("alu_d_rs_w", {30'd0, obs_drs}, 32'd1);
      nops(3);

      // Load -> dependent ALU on rt: one stall, then W forward into E
      issue(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, ns);
      issue(5'd0, 5'd9, 2'd3, 2'd1, 5'd11, 2'd1, ns);
      chk("load_alu_stalls", ns, 32'd1);
      chk("load_alu_e_b_w", {30'd0, E_fwd_b_sel}, 32'd1);
      chk("load_alu_cnt", stall_cnt, 32'd1);
      nops(3);

      // Load -> dependent branch: two stalls, then W forward into D
      issue(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 2'd2, ns);
      issue(5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, ns);
      chk("load_beq_stalls", ns, 32'd2);
      chk("load_beq_d_rs_w", {30'd0, obs_drs}, 32'd1);
      chk("load_beq_cnt", stall_cnt, 32'd3);
      nops(3);

      // jal -> jr $31: E forward into D
      issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, ns);
      issue(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, ns);
      chk("jal_jr_stalls", ns, 32'd0);
      chk("jal_jr_d_rs_e", {30'd0, obs_drs}, 32'd3);
      nops(3);

      // Writer of $0 followed by reader of $0: nothing forwards
      issue(5'd3, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1, ns);
      issue(5'd0, 5'd0, 2'd1, 2'd1, 5'd12, 2'd1, ns);
      chk("r0_stalls", ns, 32'd0);
      chk("r0_d_sels", {30'd0, obs_drs | obs_drt}, 32'd0);
      nops(3);

      // ALU $4 -> sw rt=$4: no stall, M forward into E, then W into M
      issue(5'd1, 5'd2, 2'd1, 2'd1, 5'd4, 2'd1, ns);
      issue(5'd2, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0, ns);
      chk("alu_sw_stalls", ns, 32'd0);
      chk("alu_sw_e_b_m", {30'd0, E_fwd_b_sel}, 32'd2);
      nops(1);
      chk("alu_sw_m_rt_w", {31'd0, M_fwd_rt_sel}, 32'd1);
      nops(3);

      // Reset while E holds a pending load to $5 and D would stall on it
      issue(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, ns);
      D_rs = 5'd5; D_rt = 5'd5; D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; D_A3 = 5'd0; D_Tnew = 2'd0;
      #1;
      chk("pre_reset_stall", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      #1;
      chk_all_zero("mid_reset");
      model_reset();
      @(posedge clk); #1;
      chk_all_zero("held_reset");
      reset = 1'b0;

      // Random instruction stream over a small register set to force hazards
      for (int i = 0; i < 400; i++) begin
         issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), ns);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
